// File: rtl/hazard_unit_pkg.sv
// Shared opcode/funct constants and FSM encoding for the hazard unit and control decoder.
// Helper functions classify the instruction sitting in ID.
package hazard_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    localparam logic [15:0] STALL_COUNT_MAX = 16'hFFFF;

    // Opcodes whose rt field is a source operand rather than a destination.
    localparam int RT_READ_NUM = 3;
    localparam logic [5:0] RT_READ_OPS [RT_READ_NUM] = '{OP_RTYPE, OP_BEQ, OP_SW};

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BUBBLE = 2'd1,
        ST_FLUSH  = 2'd2
    } hazardState_t;

    function automatic logic isJump(input logic [5:0] opCode, input logic [5:0] funct);
        return (opCode == OP_J) || (opCode == OP_JAL) ||
               ((opCode == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR)));
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use stall, taken-branch flush and jump flush control for a 5-stage pipeline.
// Tracks the load in EX and counts every cycle spent on a bubble or flush.
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  OpCodeID,
    input  logic [5:0]  FunctID,
    input  logic [4:0]  RsID,
    input  logic [4:0]  RtID,
    input  logic        BranchTakenEX,
    output logic        stall,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXFlush,
    output logic [15:0] StallCount
);

    hazardState_t stateReg, stateNext;
    logic         ldValidReg, ldValidNext;
    logic [4:0]   ldRtReg;
    logic [15:0]  stallCountReg;

    logic [RT_READ_NUM-1:0] rtReadHit;
    logic                   rtRead;
    logic                   hazard;
    logic                   jumpID;

    genvar gi;
    generate
        for (gi = 0; gi < RT_READ_NUM; gi++) begin : gRtRead
            assign rtReadHit[gi] = (OpCodeID == RT_READ_OPS[gi]);
        end
    endgenerate

    assign rtRead = |rtReadHit;
    assign jumpID = isJump(OpCodeID, FunctID);

    // ld_v is already 0 in BUBBLE and FLUSH, so hazard can only fire in RUN.
    assign hazard = ldValidReg && (ldRtReg != 5'd0) &&
                    ((ldRtReg == RsID) || (rtRead && (ldRtReg == RtID)));

    always_comb begin
        stall     = 1'b0;
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IFIDFlush = 1'b0;
        IDEXFlush = 1'b0;
        stateNext = ST_RUN;
        if (reset) begin
            stateNext = ST_RUN;
        end else if (BranchTakenEX && (stateReg != ST_FLUSH)) begin
            // A taken branch squashes whatever ID holds, including a stalled load consumer.
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
            stateNext = ST_FLUSH;
        end else begin
            case (stateReg)
                ST_RUN: begin
                    if (hazard) begin
                        stall     = 1'b1;
                        PCWrite   = 1'b0;
                        IFIDWrite = 1'b0;
                        IDEXFlush = 1'b1;
                        stateNext = ST_BUBBLE;
                    end else if (jumpID) begin
                        IFIDFlush = 1'b1;
                    end
                end
                ST_BUBBLE: begin
                    // A jump held by the stall is accepted now and squashes its fall-through fetch.
                    if (jumpID) begin
                        IFIDFlush = 1'b1;
                    end
                    stateNext = ST_RUN;
                end
                ST_FLUSH: stateNext = ST_RUN;
                default:  stateNext = ST_RUN;
            endcase
        end
    end

    assign ldValidNext = (OpCodeID == OP_LW) && !stall && !IDEXFlush && (stateReg != ST_FLUSH);

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg      <= ST_RUN;
            ldValidReg    <= 1'b0;
            ldRtReg       <= 5'd0;
            stallCountReg <= 16'd0;
        end else begin
            stateReg   <= stateNext;
            ldValidReg <= ldValidNext;
            ldRtReg    <= RtID;
            if ((stall || IFIDFlush || IDEXFlush) && (stallCountReg != STALL_COUNT_MAX)) begin
                stallCountReg <= stallCountReg + 16'd1;
            end
        end
    end

    assign StallCount = stallCountReg;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized pipeline traffic
// compared against a cycle-level behavioural model of the hazard rules.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  OpCodeID = 6'd0;
    logic [5:0]  FunctID = 6'd0;
    logic [4:0]  RsID = 5'd0;
    logic [4:0]  RtID = 5'd0;
    logic        BranchTakenEX = 1'b0;
    logic        stall, PCWrite, IFIDWrite, IFIDFlush, IDEXFlush;
    logic [15:0] StallCount;

    int checks = 0;
    int errors = 0;
    bit verbose = 1'b1;

    // Behavioural model: which register the load now in EX writes, what the previous cycle did.
    bit       mLoadInEx = 1'b0;
    bit [4:0] mLoadDest = 5'd0;
    int       mPrevAction = 0;     // 0 normal, 1 load-use stall, 2 branch flush
    int       mCount = 0;
    logic     eStall = 1'b0, ePCWrite = 1'b1, eIFIDWrite = 1'b1, eIFIDFlush = 1'b0, eIDEXFlush = 1'b0;
    int       eAction = 0;

    localparam logic [4:0] V_DEFAULT = 5'b01100;
    localparam logic [4:0] V_STALL   = 5'b10001;
    localparam logic [4:0] V_BRANCH  = 5'b01111;
    localparam logic [4:0] V_JUMP    = 5'b01110;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk(clk), .reset(reset), .OpCodeID(OpCodeID), .FunctID(FunctID),
        .RsID(RsID), .RtID(RtID), .BranchTakenEX(BranchTakenEX),
        .stall(stall), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush), .StallCount(StallCount)
    );

    function automatic logic [4:0] outVec();
        return {stall, PCWrite, IFIDWrite, IFIDFlush, IDEXFlush};
    endfunction

    function automatic logic [4:0] expVec();
        return {eStall, ePCWrite, eIFIDWrite, eIFIDFlush, eIDEXFlush};
    endfunction

    task automatic setExp(input logic [4:0] v, input int action);
        {eStall, ePCWrite, eIFIDWrite, eIFIDFlush, eIDEXFlush} = v;
        eAction = action;
    endtask

    task automatic modelEval();
        bit readsRt, isJmp, uses;
        readsRt = (OpCodeID == 6'h00) || (OpCodeID == 6'h04) || (OpCodeID == 6'h2b);
        isJmp   = (OpCodeID == 6'h02) || (OpCodeID == 6'h03) ||
                  ((OpCodeID == 6'h00) && ((FunctID == 6'h08) || (FunctID == 6'h09)));
        uses    = mLoadInEx && (mLoadDest != 0) &&
                  ((mLoadDest == RsID) || (readsRt && (mLoadDest == RtID)));
        if (reset)                                  setExp(V_DEFAULT, 0);
        else if (BranchTakenEX && mPrevAction != 2) setExp(V_BRANCH, 2);
        else if (mPrevAction == 2)                  setExp(V_DEFAULT, 0);
        else if (uses)                              setExp(V_STALL, 1);
        else if (isJmp)                             setExp(V_JUMP, 0);
        else                                        setExp(V_DEFAULT, 0);
    endtask

    task automatic modelAdvance();
        if (reset) begin
            mLoadInEx = 0; mLoadDest = 0; mPrevAction = 0; mCount = 0;
        end else begin
            mLoadInEx = (OpCodeID == 6'h23) && !eStall && !eIDEXFlush && (mPrevAction != 2);
            mLoadDest = RtID;
            if ((eStall || eIFIDFlush || eIDEXFlush) && mCount < 65535) mCount++;
            mPrevAction = eAction;
        end
    endtask

    // One pipeline cycle: inputs change just after the edge, outputs sampled on the falling edge.
    task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                       input logic [4:0] rt, input logic br, input logic rst);
        @(posedge clk);
        modelAdvance();
        #1;
        OpCodeID = op; FunctID = fn; RsID = rs; RtID = rt; BranchTakenEX = br; reset = rst;
        @(negedge clk);
        modelEval();
        if (verbose)
            $display("t=%0t op=%h fn=%h rs=%0d rt=%0d br=%b rst=%b -> stall=%b pcw=%b ifidw=%b ifidfl=%b idexfl=%b cnt=%0d",
                     $time, op, fn, rs, rt, br, rst, stall, PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, StallCount);
    endtask

    task automatic doReset();
        cyc(6'h00, 6'h00, 5'd0, 5'd0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if (outVec() !== V_DEFAULT) begin errors++; $display("FAIL reset_outputs: got %b want %b", outVec(), V_DEFAULT); end
        checks++;
        if (StallCount !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", StallCount); end
        cyc(6'h00, 6'h20, 5'd0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (outVec() !== V_DEFAULT || StallCount !== 16'd0) begin
            errors++; $display("FAIL post_reset: got %b cnt=%0d want %b cnt=0", outVec(), StallCount, V_DEFAULT);
        end
    endtask

    task automatic test_load_use();
        doReset();
        cyc(6'h23, 6'h00, 5'd1, 5'd5, 1'b0, 1'b0);
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL lu_load_cycle: stall=%b want 0", stall); end
        cyc(6'h00, 6'h20, 5'd5, 5'd6, 1'b0, 1'b0);
        checks++;
        if (outVec() !== V_STALL) begin errors++; $display("FAIL lu_stall: got %b want %b", outVec(), V_STALL); end
        cyc(6'h00, 6'h20, 5'd5, 5'd6, 1'b0, 1'b0);
        checks++;
        if (outVec() !== V_DEFAULT) begin errors++; $display("FAIL lu_single_stall: got %b want %b", outVec(), V_DEFAULT); end
        checks++;
        if (StallCount !== 16'd1) begin errors++; $display("FAIL lu_count: got %0d want 1", StallCount); end
    endtask

    task automatic test_no_hazard();
        doReset();
        cyc(6'h23, 6'h00, 5'd1, 5'd0, 1'b0, 1'b0);
        cyc(6'h00, 6'h20, 5'd0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL nh_reg0: stall=%b want 0", stall); end
        cyc(6'h23, 6'h00, 5'd1, 5'd5, 1'b0, 1'b0);
        cyc(6'h08, 6'h00, 5'd1, 5'd5, 1'b0, 1'b0);
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL nh_addi_rt: stall=%b want 0", stall); end
        cyc(6'h23, 6'h00, 5'd1, 5'd5, 1'b0, 1'b0);
        cyc(6'h2b, 6'h00, 5'd1, 5'd5, 1'b0, 1'b0);
        checks++;
        if (outVec() !== V_STALL) begin errors++; $display("FAIL nh_sw_rt_read: got %b want %b", outVec(), V_STALL); end
        cyc(6'h2b, 6'h00, 5'd1, 5'd5, 1'b0, 1'b0);
        checks++;
        if (outVec() !== V_DEFAULT || StallCount !== 16'd1) begin
            errors++; $display("FAIL nh_sw_bubble: got %b cnt=%0d want %b cnt=1", outVec(), StallCount, V_DEFAULT);
        end
    endtask

    task automatic test_branch_over_stall();
        doReset();
        cyc(6'h23, 6'h00, 5'd2, 5'd7, 1'b0, 1'b0);
        cyc(6'h00, 6'h20, 5'd7, 5'd3, 1'b1, 1'b0);
        checks++;
        if (outVec() !== V_BRANCH) begin errors++; $display("FAIL br_priority: got %b want %b", outVec(), V_BRANCH); end
        cyc(6'h00, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (dut.stateReg !== ST_FLUSH || dut.ldValidReg !== 1'b0) begin
            errors++; $display("FAIL br_flush_state: state=%0d ldv=%b want %0d ldv=0", dut.stateReg, dut.ldValidReg, ST_FLUSH);
        end
        checks++;
        if (outVec() !== V_DEFAULT) begin errors++; $display("FAIL br_flush_outputs: got %b want %b", outVec(), V_DEFAULT); end
        cyc(6'h00, 6'h20, 5'd7, 5'd3, 1'b0, 1'b0);
        checks++;
        if (outVec() !== V_DEFAULT || StallCount !== 16'd1) begin
            errors++; $display("FAIL br_no_residual: got %b cnt=%0d want %b cnt=1", outVec(), StallCount, V_DEFAULT);
        end
    endtask

    task automatic test_jump();
        doReset();
        cyc(6'h00, 6'h08, 5'd3, 5'd0, 1'b0, 1'b0);
        checks++;
        if (outVec() !== V_JUMP) begin errors++; $display("FAIL jr_flush: got %b want %b", outVec(), V_JUMP); end
        cyc(6'h00, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (IFIDFlush !== 1'b0) begin errors++; $display("FAIL jr_one_cycle: ifidflush=%b want 0", IFIDFlush); end
        cyc(6'h02, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (outVec() !== V_JUMP) begin errors++; $display("FAIL j_flush: got %b want %b", outVec(), V_JUMP); end
        cyc(6'h00, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0);
        cyc(6'h23, 6'h00, 5'd1, 5'd4, 1'b0, 1'b0);
        cyc(6'h00, 6'h08, 5'd4, 5'd0, 1'b0, 1'b0);
        checks++;
        if (outVec() !== V_STALL) begin errors++; $display("FAIL jr_hazard_stall: got %b want %b", outVec(), V_STALL); end
        cyc(6'h00, 6'h08, 5'd4, 5'd0, 1'b0, 1'b0);
        checks++;
        if (outVec() !== V_JUMP) begin errors++; $display("FAIL jr_delayed_flush: got %b want %b", outVec(), V_JUMP); end
        cyc(6'h00, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (outVec() !== V_DEFAULT || StallCount !== 16'd4) begin
            errors++; $display("FAIL jr_count: got %b cnt=%0d want %b cnt=4", outVec(), StallCount, V_DEFAULT);
        end
    endtask

    task automatic test_reset_in_bubble();
        doReset();
        cyc(6'h23, 6'h00, 5'd1, 5'd5, 1'b0, 1'b0);
        cyc(6'h00, 6'h20, 5'd5, 5'd6, 1'b0, 1'b0);
        checks++;
        if (outVec() !== V_STALL) begin errors++; $display("FAIL rb_stall: got %b want %b", outVec(), V_STALL); end
        cyc(6'h00, 6'h20, 5'd5, 5'd6, 1'b0, 1'b1);
        checks++;
        if (outVec() !== V_DEFAULT) begin errors++; $display("FAIL rb_reset_cycle: got %b want %b", outVec(), V_DEFAULT); end
        cyc(6'h00, 6'h20, 5'd5, 5'd6, 1'b0, 1'b0);
        checks++;
        if (dut.stateReg !== ST_RUN || outVec() !== V_DEFAULT || StallCount !== 16'd0) begin
            errors++; $display("FAIL rb_after_reset: state=%0d out=%b cnt=%0d want %0d %b 0",
                               dut.stateReg, outVec(), StallCount, ST_RUN, V_DEFAULT);
        end
    endtask

    task automatic test_random();
        logic [5:0] op, fn;
        logic [4:0] rs, rt;
        logic       br, rst;
        int         kind;
        doReset();
        op = 0; fn = 0; rs = 0; rt = 0;
        for (int i = 0; i < 2000; i++) begin
            // Drive ID the way the pipeline would: nop after a flush, held during a stall.
            if (eIFIDFlush) begin
                op = 0; fn = 0; rs = 0; rt = 0;
            end else if (eIFIDWrite) begin
                kind = $urandom_range(0, 8);
                rs = 5'($urandom_range(0, 3));
                rt = 5'($urandom_range(0, 3));
                fn = 6'h20;
                case (kind)
                    0: op = 6'h23;
                    1: op = 6'h2b;
                    2: op = 6'h04;
                    3: op = 6'h00;
                    4: op = 6'h08;
                    5: op = 6'h02;
                    6: op = 6'h03;
                    7: begin op = 6'h00; fn = 6'h08; end
                    default: begin op = 6'h00; fn = 6'h09; end
                endcase
            end
            br  = (eAction != 2) && ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 99) == 0);
            cyc(op, fn, rs, rt, br, rst);
            checks++;
            if (outVec() !== expVec()) begin
                errors++; $display("FAIL rand_outputs[%0d]: got %b want %b", i, outVec(), expVec());
            end
            checks++;
            if (StallCount !== 16'(mCount)) begin
                errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, StallCount, mCount);
            end
        end
    endtask

    task automatic test_saturation();
        verbose = 1'b0;
        doReset();
        for (int i = 0; i < 65533; i++) cyc(6'h00, 6'h08, 5'd3, 5'd0, 1'b0, 1'b0);
        verbose = 1'b1;
        cyc(6'h23, 6'h00, 5'd1, 5'd5, 1'b0, 1'b0);
        checks++;
        if (StallCount !== 16'hFFFD) begin errors++; $display("FAIL sat_preload: got %h want fffd", StallCount); end
        for (int s = 0; s < 3; s++) begin
            if (s > 0) cyc(6'h23, 6'h00, 5'd1, 5'd5, 1'b0, 1'b0);
            cyc(6'h00, 6'h20, 5'd5, 5'd6, 1'b0, 1'b0);
            checks++;
            if (stall !== 1'b1) begin errors++; $display("FAIL sat_stall[%0d]: stall=%b want 1", s, stall); end
            cyc(6'h00, 6'h20, 5'd5, 5'd6, 1'b0, 1'b0);
        end
        checks++;
        if (StallCount !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", StallCount); end
        cyc(6'h00, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (StallCount !== 16'hFFFF || StallCount !== 16'(mCount)) begin
            errors++; $display("FAIL sat_no_wrap: got %h want ffff (model %0d)", StallCount, mCount);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch_over_stall();
        test_jump();
        test_reset_in_bubble();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL expose `clk`, input, 1 bit: the single pipeline clock; all state updates on its rising edge.
REQ-002 SHALL expose `reset`, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of `clk`.
REQ-003 SHALL expose `OpCodeID`, input, 6 bits: opcode of the instruction in ID.
REQ-004 SHALL expose `FunctID`, input, 6 bits: funct field of the instruction in ID.
REQ-005 SHALL expose `RsID`, input, 5 bits: rs field of the instruction in ID.
REQ-006 SHALL expose `RtID`, input, 5 bits: rt field of the instruction in ID.
REQ-007 SHALL expose `BranchTakenEX`, input, 1 bit: the beq in EX resolved taken this cycle.
REQ-008 SHALL expose `stall`, output, 1 bit: bubble request to the control decoder, forcing its write/branch controls to 0.
REQ-009 SHALL expose `PCWrite`, output, 1 bit: PC update enable.
REQ-010 SHALL expose `IFIDWrite`, output, 1 bit: IF/ID register enable.
REQ-011 SHALL expose `IFIDFlush`, output, 1 bit: zero the IF/ID register at the next edge.
REQ-012 SHALL expose `IDEXFlush`, output, 1 bit: zero the ID/EX register at the next edge.
REQ-013 SHALL expose `StallCount`, output, 16 bits: saturating count of bubble cycles.

Function
REQ-014 SHALL track the load in EX internally: `ld_v` and `ld_rt` (5 bits) are loaded each edge with (OpCodeID==0x23 && !stall && !IDEXFlush) and RtID.
REQ-015 SHALL define rt-read as OpCodeID in {0x00, 0x04, 0x2b}.
REQ-016 SHALL define hazard = ld_v && ld_rt!=0 && (ld_rt==RsID || (rt-read && ld_rt==RtID)).
REQ-017 SHALL implement FSM states RUN, BUBBLE and FLUSH, encoded in 2 bits.
REQ-018 SHALL, in RUN with hazard and !BranchTakenEX, drive stall=1, PCWrite=0, IFIDWrite=0 and IDEXFlush=1 combinationally in the same cycle, then go to BUBBLE.
REQ-019 SHALL, in BUBBLE, drive all enables high with stall=0, ignore hazard because ld_v is 0, and return to RUN.
REQ-020 SHALL, whenever BranchTakenEX=1 in any state, drive IFIDFlush=1, IDEXFlush=1, stall=0, PCWrite=1 and IFIDWrite=1, and go to FLUSH; branch outranks load stall.
REQ-021 SHALL, in FLUSH, drive default outputs, clear ld_v and return to RUN; a second taken branch in FLUSH is impossible because EX holds a bubble, and is ignored.
REQ-022 SHALL, in RUN with OpCodeID in {0x02, 0x03}, or OpCodeID==0x00 with FunctID in {0x08, 0x09}, and no hazard, drive IFIDFlush=1 for one cycle; a hazard delays this flush until the jump is accepted.
REQ-023 SHALL use defaults stall=0, PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXFlush=0.
REQ-024 SHALL increment StallCount each cycle stall=1 or IFIDFlush=1 or IDEXFlush=1, saturating at 0xFFFF with no wrap.
REQ-025 SHALL never assert stall for two consecutive cycles for a single load.

Reset
REQ-026 SHALL, on reset, set the state to RUN, ld_v=0, ld_rt=0 and StallCount=0, and drive outputs to the REQ-023 defaults in the reset cycle.
REQ-027 SHALL, on reset mid-stall or mid-flush, abandon the operation with no residual bubble after reset deasserts.

Structure
REQ-028 SHALL place opcode/funct constants (LW 0x23, SW 0x2b, BEQ 0x04, J 0x02, JAL 0x03, JR 0x08, JALR 0x09) and the FSM state encoding in a shared package also used by the control decoder.
REQ-029 SHALL contain no sub-module; the saturating counter stays inline.

Verification
REQ-030 SHALL check load-use: lw $5 in ID at cycle 0, then add rs=5 in ID at cycle 1 -> stall=1, PCWrite=0 at cycle 1 only, StallCount=1, stall=0 at cycle 2.
REQ-031 SHALL check no hazard: lw $0 followed by add rs=0, or lw $5 followed by addi rt=5 (no rt-read) -> stall stays 0.
REQ-032 SHALL check branch over stall: hazard and BranchTakenEX=1 in the same cycle -> stall=0, IFIDFlush=1, IDEXFlush=1, FSM goes to FLUSH, ld_v=0 next cycle.
REQ-033 SHALL check jump: jr (op 0x00, funct 0x08) in ID -> IFIDFlush=1 for exactly one cycle, PCWrite=1.
REQ-034 SHALL check saturation: StallCount preloaded near 0xFFFF and driven with 3 further stalls -> holds 0xFFFF.
REQ-035 SHALL check reset while in BUBBLE -> next cycle state RUN, all outputs at defaults, StallCount=0.
